// File: rtl/branch_sequencer.sv
// Branch/jump resolution sequencer: accepts one control-transfer request,
// borrows the shared comparator for conditional branches, and returns the
// resolved outcome with mispredict flush and a saturating mispredict count.
module branch_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // request side
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_kind,
    input  logic [2:0]       req_funct3,
    input  logic [XLEN-1:0]  req_pc,
    input  logic [XLEN-1:0]  req_imm,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic             req_pred_taken,
    input  logic             kill,
    // shared comparator
    output logic             cmp_req,
    input  logic             cmp_gnt,
    output logic [XLEN-1:0]  cmp_x,
    output logic [XLEN-1:0]  cmp_y,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    input  logic             cmp_ltu,
    // result side
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_taken,
    output logic [XLEN-1:0]  res_target,
    output logic [XLEN-1:0]  res_link,
    output logic             res_mispredict,
    output logic             res_illegal,
    output logic             res_misaligned,
    output logic             flush,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [1:0] KIND_BR   = 2'b00;
    localparam logic [1:0] KIND_JAL  = 2'b01;
    localparam logic [1:0] KIND_JALR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CMP  = 2'b01,
        S_RESP = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             pred_q, pred_d;
    logic [XLEN-1:0]  target_q, target_d;
    logic [XLEN-1:0]  link_q, link_d;
    logic             taken_q, taken_d;
    logic             illegal_q, illegal_d;
    logic             misal_q, misal_d;
    logic             mispred_q, mispred_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             xfer;
    logic             done;
    logic             br_taken;
    logic [XLEN-1:0]  sum_pc;
    logic [XLEN-1:0]  sum_rs;
    logic [XLEN-1:0]  jalr_tgt;

    // Handshake qualifiers; reset blocks acceptance, kill blocks both sides
    assign req_ready = rst_n && (state_q == S_IDLE) && !kill;
    assign xfer      = req_valid && req_ready;
    assign done      = (state_q == S_RESP) && res_ready && !kill;

    // Target adders; carries out of XLEN are dropped by the sized sums
    assign sum_pc   = req_pc + req_imm;
    assign sum_rs   = req_rs1 + req_imm;
    assign jalr_tgt = {sum_rs[XLEN-1:1], 1'b0};

    // Condition decode from the comparator flags
    always_comb begin
        br_taken = 1'b0;
        case (funct3_q)
            3'b000:  br_taken = cmp_eq;
            3'b001:  br_taken = !cmp_eq;
            3'b100:  br_taken = cmp_lt;
            3'b101:  br_taken = !cmp_lt;
            3'b110:  br_taken = cmp_ltu;
            3'b111:  br_taken = !cmp_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    // Next-state and result capture
    always_comb begin
        state_d   = state_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        funct3_d  = funct3_q;
        pred_d    = pred_q;
        target_d  = target_q;
        link_d    = link_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        misal_d   = misal_q;
        mispred_d = mispred_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    rs1_d    = req_rs1;
                    rs2_d    = req_rs2;
                    funct3_d = req_funct3;
                    pred_d   = req_pred_taken;
                    link_d   = req_pc + XLEN'(4);
                    case (req_kind)
                        KIND_BR: begin
                            target_d  = sum_pc;
                            taken_d   = 1'b0;
                            illegal_d = (req_funct3 == 3'b010) || (req_funct3 == 3'b011);
                            misal_d   = 1'b0;
                            mispred_d = 1'b0;
                            state_d   = S_CMP;
                        end
                        KIND_JAL: begin
                            target_d  = sum_pc;
                            taken_d   = 1'b1;
                            illegal_d = 1'b0;
                            misal_d   = sum_pc[1];
                            mispred_d = !req_pred_taken;
                            state_d   = S_RESP;
                        end
                        KIND_JALR: begin
                            target_d  = jalr_tgt;
                            taken_d   = 1'b1;
                            illegal_d = 1'b0;
                            misal_d   = jalr_tgt[1];
                            mispred_d = !req_pred_taken;
                            state_d   = S_RESP;
                        end
                        default: begin
                            target_d  = sum_pc;
                            taken_d   = 1'b0;
                            illegal_d = 1'b1;
                            misal_d   = 1'b0;
                            mispred_d = 1'b0;
                            state_d   = S_RESP;
                        end
                    endcase
                end
            end
            S_CMP: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else if (cmp_gnt) begin
                    // Illegal conditions decode to not-taken and never mispredict
                    taken_d   = br_taken;
                    misal_d   = br_taken && target_q[1];
                    mispred_d = (br_taken != pred_q) && !illegal_q;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else if (res_ready) begin
                    state_d = S_IDLE;
                    if (mispred_q && (cnt_q != {CNT_W{1'b1}})) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched request/result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            funct3_q  <= '0;
            pred_q    <= 1'b0;
            target_q  <= '0;
            link_q    <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            misal_q   <= 1'b0;
            mispred_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            funct3_q  <= funct3_d;
            pred_q    <= pred_d;
            target_q  <= target_d;
            link_q    <= link_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
            misal_q   <= misal_d;
            mispred_q <= mispred_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cmp_req        = (state_q == S_CMP);
    assign cmp_x          = rs1_q;
    assign cmp_y          = rs2_q;
    assign res_valid      = (state_q == S_RESP);
    assign res_taken      = taken_q;
    assign res_target     = target_q;
    assign res_link       = link_q;
    assign res_mispredict = mispred_q;
    assign res_illegal    = illegal_q;
    assign res_misaligned = misal_q;
    assign flush          = done && mispred_q;
    assign mispred_cnt    = cnt_q;

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter XLEN, default 32, operand/PC width.
REQ-002 Parameter CNT_W, default 16, mispredict counter width.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  branch/jump request present.
REQ-006 req_ready  out  1  block accepts request this cycle.
REQ-007 req_kind  in  2  00 cond branch, 01 JAL, 10 JALR, 11 reserved.
REQ-008 req_funct3  in  3  branch condition (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU).
REQ-009 req_pc, req_imm, req_rs1, req_rs2  in  XLEN each  instruction PC, sign-extended immediate, operands.
REQ-010 req_pred_taken  in  1  fetch-stage prediction.
REQ-011 kill  in  1  cancel in-flight request (older-instruction flush).
REQ-012 cmp_req  out  1  request for the shared comparator.
REQ-013 cmp_gnt  in  1  comparator granted; cmp_eq/lt/ltu valid same cycle.
REQ-014 cmp_x, cmp_y  out  XLEN  latched rs1/rs2 driven to comparator.
REQ-015 cmp_eq, cmp_lt, cmp_ltu  in  1 each  comparator results (signed lt, unsigned ltu).
REQ-016 res_valid  out  1 / res_ready  in  1  result handshake.
REQ-017 res_taken  out  1, res_target  out  XLEN, res_link  out  XLEN (pc+4).
REQ-018 res_mispredict, res_illegal, res_misaligned  out  1 each  result flags.
REQ-019 flush  out  1  one-cycle pulse on acceptance of a mispredicted result.
REQ-020 mispred_cnt  out  CNT_W  saturating mispredict count.

Function
REQ-021 FSM states IDLE, CMP, RESP; SHALL be in IDLE after reset.
REQ-022 req_ready SHALL equal (state==IDLE && !kill); transfer when req_valid && req_ready; all req_* latched on transfer.
REQ-023 Transfer with kind 00 -> CMP; kind 01/10 -> RESP (no comparator use); kind 11 -> RESP with res_illegal=1, res_taken=0.
REQ-024 In CMP, cmp_req=1 and cmp_x/cmp_y held at latched rs1/rs2 until cmp_gnt; on cmp_gnt, outcome latched and -> RESP next cycle; cmp_req=0 in all other states.
REQ-025 Taken: BEQ eq; BNE !eq; BLT lt; BGE !lt; BLTU ltu; BGEU !ltu; funct3 010/011 -> taken=0, res_illegal=1; JAL/JALR taken=1.
REQ-026 Target: branch/JAL = pc+imm; JALR = (rs1+imm) with bit0 cleared; all sums modulo 2^XLEN, carry discarded.
REQ-027 res_misaligned = res_taken && target[1]; res_link = pc+4 modulo 2^XLEN.
REQ-028 res_mispredict = (res_taken != latched pred_taken) && !res_illegal.
REQ-029 In RESP, res_valid=1 with all res_* stable until res_valid && res_ready, then -> IDLE next cycle.
REQ-030 flush SHALL pulse exactly on the res_valid && res_ready cycle when res_mispredict=1; mispred_cnt increments by 1 on that cycle, saturating at all-ones.
REQ-031 Minimum latency: branch with immediate grant and res_ready=1 -> res_valid 2 cycles after transfer; JAL/JALR -> 1 cycle.
REQ-032 kill in CMP or RESP -> IDLE next cycle; no handshake completes, no flush, no count that cycle; cmp_req deasserted the cycle after kill.
REQ-033 kill and res_ready in the same RESP cycle: kill wins (no flush, no count).
REQ-034 No new request accepted while CMP or RESP; one request in flight maximum.

Reset
REQ-035 On rst_n low, immediately: state IDLE, req_ready=0 while rst_n low, res_valid=0, cmp_req=0, flush=0, mispred_cnt=0, latched fields 0.
REQ-036 Reset mid-operation discards the request; first acceptance allowed on the first edge after rst_n rises.

Verification
REQ-037 BEQ rs1=rs2=5, pred 0, gnt immediate, res_ready=1 -> res_valid at cycle 2, taken=1, target=pc+imm, mispredict=1, flush one cycle, cnt=1.
REQ-038 BLT rs1=0xFFFFFFFF, rs2=1 taken; BLTU same operands not taken; BGE with eq=1 taken.
REQ-039 JALR rs1=0x1001, imm=2 -> target 0x1002, misaligned=1, link=pc+4, latency 1; pc=0xFFFFFFFC JAL link wraps to 0.
REQ-040 cmp_gnt withheld 3 cycles then res_ready low 2 cycles -> cmp_x/y and res_* stable throughout, req_ready=0.
REQ-041 kill in CMP, then kill coincident with res_ready in RESP -> IDLE, no flush, cnt unchanged; funct3 010 -> illegal=1, taken=0.
REQ-042 Force cnt to all-ones, mispredict again -> cnt holds; assert rst_n low in RESP -> res_valid=0 immediately, cnt=0.
